// File: rtl/quote_scheduler.sv
// Market-data front end: coalesces best bid/ask per stock and issues one stock at a time, round-robin, to the pricing pipeline.
// Optional WAIT watchdog enabled by defining QUOTE_SCHED_TIMEOUT_EN.
module quote_scheduler #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_STOCKS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_md_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_md_stock_id,
  input  logic [DATA_WIDTH-1:0]         i_md_best_ask,
  input  logic [DATA_WIDTH-1:0]         i_md_best_bid,
  output logic                          o_tl_data_valid,
  output logic [$clog2(NUM_STOCKS)-1:0] o_tl_stock_id,
  output logic [DATA_WIDTH-1:0]         o_tl_best_ask,
  output logic [DATA_WIDTH-1:0]         o_tl_best_bid,
  input  logic                          i_tl_done,
  output logic                          o_busy,
  output logic [NUM_STOCKS-1:0]         o_pending,
  output logic                          o_coalesced,
  output logic [15:0]                   o_coalesce_cnt,
  output logic                          o_timeout
);

  localparam int unsigned IDW  = $clog2(NUM_STOCKS);
  localparam int unsigned CNTW = 16;

  if ((NUM_STOCKS < 2) || ((NUM_STOCKS & (NUM_STOCKS - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("quote_scheduler: NUM_STOCKS must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_ask [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] r_bid [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] r_pending;
  logic [IDW-1:0]        r_last_id;
  logic                  r_tl_valid;
  logic [IDW-1:0]        r_tl_stock_id;
  logic [DATA_WIDTH-1:0] r_tl_ask;
  logic [DATA_WIDTH-1:0] r_tl_bid;
  logic                  r_busy;
  logic                  r_coalesced;
  logic [CNTW-1:0]       r_coalesce_cnt;

  logic                  w_found;
  logic [IDW-1:0]        w_winner;
  logic [IDW-1:0]        w_cand;
  logic [NUM_STOCKS-1:0] w_pending_nxt;
  logic                  w_coalesce;

  // Round-robin pick: first pending slot after last_id, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_id;
    w_cand   = r_last_id;
    for (int unsigned k = 1; k <= NUM_STOCKS; k++) begin
      w_cand = r_last_id + IDW'(k);
      if (!w_found && r_pending[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // A write to the slot being issued this cycle wins over the clear and is not a coalesce.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_state == S_ISSUE) w_pending_nxt[r_tl_stock_id] = 1'b0;
    if (i_md_valid)         w_pending_nxt[i_md_stock_id] = 1'b1;
    w_coalesce = i_md_valid && r_pending[i_md_stock_id] &&
                 !((r_state == S_ISSUE) && (i_md_stock_id == r_tl_stock_id));
  end

`ifdef QUOTE_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout;
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_pending      <= '0;
      r_last_id      <= IDW'(NUM_STOCKS - 1);
      r_tl_valid     <= 1'b0;
      r_tl_stock_id  <= '0;
      r_tl_ask       <= '0;
      r_tl_bid       <= '0;
      r_busy         <= 1'b0;
      r_coalesced    <= 1'b0;
      r_coalesce_cnt <= '0;
      for (int i = 0; i < int'(NUM_STOCKS); i++) begin
        r_ask[i] <= '0;
        r_bid[i] <= '0;
      end
`ifdef QUOTE_SCHED_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_tl_valid  <= 1'b0;
      r_coalesced <= 1'b0;
      r_pending   <= w_pending_nxt;
`ifdef QUOTE_SCHED_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
      if (i_md_valid) begin
        r_ask[i_md_stock_id] <= i_md_best_ask;
        r_bid[i_md_stock_id] <= i_md_best_bid;
      end
      if (w_coalesce) begin
        r_coalesced <= 1'b1;
        if (r_coalesce_cnt != {CNTW{1'b1}}) r_coalesce_cnt <= CNTW'(r_coalesce_cnt + CNTW'(1));
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_tl_stock_id <= w_winner;
            r_tl_ask      <= r_ask[w_winner];
            r_tl_bid      <= r_bid[w_winner];
            r_tl_valid    <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_last_id <= r_tl_stock_id;
          r_state   <= S_WAIT;
`ifdef QUOTE_SCHED_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (i_tl_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
`ifdef QUOTE_SCHED_TIMEOUT_EN
          // Expiry drops the in-flight update; it is not re-queued.
          else if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wait_cnt <= TW'(r_wait_cnt + TW'(1));
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tl_data_valid = r_tl_valid;
  assign o_tl_stock_id   = r_tl_stock_id;
  assign o_tl_best_ask   = r_tl_ask;
  assign o_tl_best_bid   = r_tl_bid;
  assign o_busy          = r_busy;
  assign o_pending       = r_pending;
  assign o_coalesced     = r_coalesced;
  assign o_coalesce_cnt  = r_coalesce_cnt;

endmodule

// File: tb/tb_quote_scheduler.sv
// Directed bench for quote_scheduler: per-cycle vector table plus hand sequences for round-robin order and reset mid-WAIT.
module tb_quote_scheduler;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_md_valid;
  logic [1:0]  i_md_stock_id;
  logic [31:0] i_md_best_ask;
  logic [31:0] i_md_best_bid;
  logic        o_tl_data_valid;
  logic [1:0]  o_tl_stock_id;
  logic [31:0] o_tl_best_ask;
  logic [31:0] o_tl_best_bid;
  logic        i_tl_done;
  logic        o_busy;
  logic [3:0]  o_pending;
  logic        o_coalesced;
  logic [15:0] o_coalesce_cnt;
  logic        o_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  quote_scheduler #(.DATA_WIDTH(32), .NUM_STOCKS(4), .TIMEOUT_CYCLES(64)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_md_valid     (i_md_valid),
    .i_md_stock_id  (i_md_stock_id),
    .i_md_best_ask  (i_md_best_ask),
    .i_md_best_bid  (i_md_best_bid),
    .o_tl_data_valid(o_tl_data_valid),
    .o_tl_stock_id  (o_tl_stock_id),
    .o_tl_best_ask  (o_tl_best_ask),
    .o_tl_best_bid  (o_tl_best_bid),
    .i_tl_done      (i_tl_done),
    .o_busy         (o_busy),
    .o_pending      (o_pending),
    .o_coalesced    (o_coalesced),
    .o_coalesce_cnt (o_coalesce_cnt),
    .o_timeout      (o_timeout)
  );

  typedef struct {
    logic        v;
    logic [1:0]  id;
    logic [31:0] ask;
    logic [31:0] bid;
    logic        done;
    logic        ev;
    logic [1:0]  eid;
    logic [31:0] eask;
    logic [31:0] ebid;
    logic        ebusy;
    logic [3:0]  epend;
    logic        ecoal;
    logic [15:0] ecnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input bit v, input int id, input int ask, input int bid, input bit d,
                              input bit ev, input int eid, input int eask, input int ebid,
                              input bit eb, input int ep, input bit ec, input int ecnt);
    vec_t r;
    r.v = v; r.id = 2'(id); r.ask = 32'(ask); r.bid = 32'(bid); r.done = d;
    r.ev = ev; r.eid = 2'(eid); r.eask = 32'(eask); r.ebid = 32'(ebid);
    r.ebusy = eb; r.epend = 4'(ep); r.ecoal = ec; r.ecnt = 16'(ecnt);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_md_valid = 1'b0; i_md_stock_id = '0;
    i_md_best_ask = '0; i_md_best_bid = '0; i_tl_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
  endtask

  task automatic md_write(input int id, input int ask, input int bid);
    @(negedge clk);
    i_md_valid = 1'b1; i_md_stock_id = 2'(id);
    i_md_best_ask = 32'(ask); i_md_best_bid = 32'(bid);
    @(posedge clk);
    #1 i_md_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    i_tl_done = 1'b1;
    @(posedge clk);
    #1 i_tl_done = 1'b0;
  endtask

  // Bounded wait for the next issue pulse, then check id and ask.
  task automatic wait_issue(input int eid, input int eask, input string nm);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (o_tl_data_valid) seen = 1'b1;
      n++;
    end
    check({nm, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({nm, "_id"},  64'(o_tl_stock_id), 64'(eid));
      check({nm, "_ask"}, 64'(o_tl_best_ask), 64'(eask));
    end
  endtask

  initial begin
    bit bad;

    // Single issue, coalesce in WAIT, RR from last_id=2, ISSUE write/clear collision, late done.
    vecs[0]  = mk(0,0,'h000,'h00,0,  0,0,'h000,'h00,0,'b0000,0,0);
    vecs[1]  = mk(1,2,'h100,'hF0,0,  0,0,'h000,'h00,0,'b0000,0,0);
    vecs[2]  = mk(0,0,0,0,0,         0,0,'h000,'h00,0,'b0100,0,0);
    vecs[3]  = mk(0,0,0,0,0,         1,2,'h100,'hF0,1,'b0100,0,0);
    vecs[4]  = mk(1,1,'h10,'h1,0,    0,2,'h100,'hF0,1,'b0000,0,0);
    vecs[5]  = mk(1,1,'h20,'h2,0,    0,2,'h100,'hF0,1,'b0010,0,0);
    vecs[6]  = mk(1,3,'h33,'h3,0,    0,2,'h100,'hF0,1,'b0010,1,1);
    vecs[7]  = mk(1,0,'h44,'h4,0,    0,2,'h100,'hF0,1,'b1010,0,1);
    vecs[8]  = mk(0,0,0,0,1,         0,2,'h100,'hF0,1,'b1011,0,1);
    vecs[9]  = mk(0,0,0,0,0,         0,2,'h100,'hF0,0,'b1011,0,1);
    vecs[10] = mk(0,0,0,0,0,         1,3,'h33,'h3,1,'b1011,0,1);
    vecs[11] = mk(0,0,0,0,1,         0,3,'h33,'h3,1,'b0011,0,1);
    vecs[12] = mk(0,0,0,0,0,         0,3,'h33,'h3,0,'b0011,0,1);
    vecs[13] = mk(1,0,'h55,'h5,0,    1,0,'h44,'h4,1,'b0011,0,1);
    vecs[14] = mk(0,0,0,0,1,         0,0,'h44,'h4,1,'b0011,0,1);
    vecs[15] = mk(0,0,0,0,0,         0,0,'h44,'h4,0,'b0011,0,1);
    vecs[16] = mk(0,0,0,0,0,         1,1,'h20,'h2,1,'b0011,0,1);
    vecs[17] = mk(0,0,0,0,1,         0,1,'h20,'h2,1,'b0001,0,1);
    vecs[18] = mk(0,0,0,0,0,         0,1,'h20,'h2,0,'b0001,0,1);
    vecs[19] = mk(0,0,0,0,0,         1,0,'h55,'h5,1,'b0001,0,1);
    vecs[20] = mk(0,0,0,0,1,         0,0,'h55,'h5,1,'b0000,0,1);
    vecs[21] = mk(0,0,0,0,0,         0,0,'h55,'h5,0,'b0000,0,1);
    vecs[22] = mk(0,0,0,0,1,         0,0,'h55,'h5,0,'b0000,0,1);
    vecs[23] = mk(0,0,0,0,0,         0,0,'h55,'h5,0,'b0000,0,1);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      i_md_valid = vecs[i].v; i_md_stock_id = vecs[i].id;
      i_md_best_ask = vecs[i].ask; i_md_best_bid = vecs[i].bid;
      i_tl_done = vecs[i].done;
      @(negedge clk);
      check($sformatf("row%0d_valid", i), 64'(o_tl_data_valid), 64'(vecs[i].ev));
      check($sformatf("row%0d_id", i),    64'(o_tl_stock_id),   64'(vecs[i].eid));
      check($sformatf("row%0d_ask", i),   64'(o_tl_best_ask),   64'(vecs[i].eask));
      check($sformatf("row%0d_bid", i),   64'(o_tl_best_bid),   64'(vecs[i].ebid));
      check($sformatf("row%0d_busy", i),  64'(o_busy),          64'(vecs[i].ebusy));
      check($sformatf("row%0d_pend", i),  64'(o_pending),       64'(vecs[i].epend));
      check($sformatf("row%0d_coal", i),  64'(o_coalesced),     64'(vecs[i].ecoal));
      check($sformatf("row%0d_cnt", i),   64'(o_coalesce_cnt),  64'(vecs[i].ecnt));
      check($sformatf("row%0d_tmo", i),   64'(o_timeout),       64'd0);
    end
    @(posedge clk);
    #1 i_md_valid = 1'b0; i_tl_done = 1'b0;

    // Round-robin from reset: 0, then 1,2,3 queued together; then 3 and 0 queued with last_id=3.
    do_reset();
    md_write(0, 'h200, 'h1F0);
    wait_issue(0, 'h200, "rr0");
    md_write(1, 'h201, 'h1F1);
    md_write(2, 'h202, 'h1F2);
    md_write(3, 'h203, 'h1F3);
    @(negedge clk);
    check("rr_pend", 64'(o_pending), 64'b1110);
    for (int k = 1; k < 4; k++) begin
      repeat (8) @(posedge clk);
      pulse_done();
      wait_issue(k, 'h200 + k, $sformatf("rr%0d", k));
    end
    md_write(3, 'h303, 'h2F3);
    md_write(0, 'h300, 'h2F0);
    @(negedge clk);
    check("rr2_pend", 64'(o_pending), 64'b1001);
    pulse_done();
    wait_issue(0, 'h300, "rr2_first");
    pulse_done();
    wait_issue(3, 'h303, "rr2_second");
    pulse_done();
    check("rr2_cnt", 64'(o_coalesce_cnt), 64'd0);

    // Park in WAIT with 1 and 3 pending, then reset mid-WAIT.
    md_write(0, 'h400, 'h3F0);
    wait_issue(0, 'h400, "rst_issue");
    md_write(1, 'h401, 'h3F1);
    md_write(3, 'h403, 'h3F3);
`ifndef QUOTE_SCHED_TIMEOUT_EN
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (o_tl_data_valid || o_timeout || !o_busy) bad = 1'b1;
    end
    check("wait_holds", 64'(bad), 64'd0);
`endif
    @(negedge clk);
    check("pre_rst_pend", 64'(o_pending), 64'b1010);
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(o_tl_data_valid), 64'd0);
    check("rst_id",    64'(o_tl_stock_id),   64'd0);
    check("rst_ask",   64'(o_tl_best_ask),   64'd0);
    check("rst_bid",   64'(o_tl_best_bid),   64'd0);
    check("rst_busy",  64'(o_busy),          64'd0);
    check("rst_pend",  64'(o_pending),       64'd0);
    check("rst_coal",  64'(o_coalesced),     64'd0);
    check("rst_cnt",   64'(o_coalesce_cnt),  64'd0);
    pulse_done();
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_tl_data_valid || o_busy || (o_pending != 4'b0)) bad = 1'b1;
    end
    check("late_done_ignored", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
